// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_NUM_LINES  = 64;
    localparam int unsigned DEF_LINE_WORDS = 4;

    localparam int unsigned OFFSET_W = $clog2(DEF_LINE_WORDS);
    localparam int unsigned INDEX_W  = $clog2(DEF_NUM_LINES);
    localparam int unsigned TAG_W    = DEF_ADDR_W - INDEX_W - OFFSET_W - 2;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL
    } state_e;

endpackage

// File: rtl/icache_fill_ctrl.sv
// Miss/line-fill sequencer: request handshake, beat counting and flush poisoning.
module icache_fill_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                                          CLK,
    input  logic                                          RESET,
    input  logic                                          lookup_miss,
    input  logic [ADDR_W-$clog2(LINE_WORDS)-3:0]          fetch_line,
    input  logic                                          Flush,
    input  logic                                          Mem_Req_Ready,
    input  logic                                          Mem_Resp_Valid,
    output state_e                                        state,
    output logic                                          poison,
    output logic                                          Mem_Req_Valid,
    output logic [ADDR_W-1:0]                             Mem_Req_Addr,
    output logic                                          wr_en_c,
    output logic                                          wr_last_c,
    output logic [$clog2(NUM_LINES)-1:0]                  wr_index_c,
    output logic [$clog2(LINE_WORDS)-1:0]                 wr_beat_c,
    output logic [ADDR_W-$clog2(LINE_WORDS)-$clog2(NUM_LINES)-3:0] wr_tag_c
);

    localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned LINE_W = ADDR_W - OFF_W - 2;

    logic [OFF_W-1:0]  beat;
    logic [LINE_W-1:0] miss_line;

    // Single-process FSM; last-beat poison clear deliberately overrides a same-cycle flush.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            beat          <= '0;
            poison        <= 1'b0;
            miss_line     <= '0;
            Mem_Req_Valid <= 1'b0;
            Mem_Req_Addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lookup_miss) begin
                        miss_line     <= fetch_line;
                        Mem_Req_Addr  <= {fetch_line, {(OFF_W + 2){1'b0}}};
                        Mem_Req_Valid <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (Flush) poison <= 1'b1;
                    if (Mem_Req_Ready) begin
                        Mem_Req_Valid <= 1'b0;
                        beat          <= '0;
                        state         <= FILL;
                    end
                end
                FILL: begin
                    if (Flush) poison <= 1'b1;
                    if (Mem_Resp_Valid) begin
                        beat <= beat + OFF_W'(1);
                        if (beat == OFF_W'(LINE_WORDS - 1)) begin
                            poison <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wr_en_c    = (state == FILL) && Mem_Resp_Valid;
        wr_last_c  = wr_en_c && (beat == OFF_W'(LINE_WORDS - 1));
        wr_index_c = miss_line[IDX_W-1:0];
        wr_beat_c  = beat;
        wr_tag_c   = miss_line[LINE_W-1:IDX_W];
    end

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache answering fetch; optional counters under ICACHE_STATS_EN.
module icache_responder
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] Instr_address_2IM,
    output logic [31:0]       Instr1_fIM,
    output logic              stall_C,
    input  logic              Flush,
    output logic              Mem_Req_Valid,
    output logic [ADDR_W-1:0] Mem_Req_Addr,
    input  logic              Mem_Req_Ready,
    input  logic              Mem_Resp_Valid,
    input  logic [31:0]       Mem_Resp_Data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       Hit_Count,
    output logic [31:0]       Miss_Count
`endif
);

    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TG_W  = ADDR_W - IDX_W - OFF_W - 2;

    logic [NUM_LINES-1:0] valid_q;
    logic [TG_W-1:0]      tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES*LINE_WORDS];

    logic [OFF_W-1:0] addr_off;
    logic [IDX_W-1:0] addr_idx;
    logic [TG_W-1:0]  addr_tag;
    logic [1:0]       unused_addr_bits;
    logic             lookup_match;
    logic             hit;

    state_e           state;
    logic             poison;
    logic             wr_en_c;
    logic             wr_last_c;
    logic [IDX_W-1:0] wr_index_c;
    logic [OFF_W-1:0] wr_beat_c;
    logic [TG_W-1:0]  wr_tag_c;

    assign addr_off         = Instr_address_2IM[OFF_W+1:2];
    assign addr_idx         = Instr_address_2IM[OFF_W+IDX_W+1:OFF_W+2];
    assign addr_tag         = Instr_address_2IM[ADDR_W-1:OFF_W+IDX_W+2];
    assign unused_addr_bits = Instr_address_2IM[1:0];

    // Lookup is purely combinational and is suppressed while a fill is in flight.
    always_comb begin
        lookup_match = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
        hit          = lookup_match && (state == IDLE);
        stall_C      = !hit;
        Instr1_fIM   = hit ? data_q[{addr_idx, addr_off}] : 32'h0;
    end

    icache_fill_ctrl #(
        .ADDR_W     (ADDR_W),
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_fill_ctrl (
        .CLK            (CLK),
        .RESET          (RESET),
        .lookup_miss    (!lookup_match),
        .fetch_line     (Instr_address_2IM[ADDR_W-1:OFF_W+2]),
        .Flush          (Flush),
        .Mem_Req_Ready  (Mem_Req_Ready),
        .Mem_Resp_Valid (Mem_Resp_Valid),
        .state          (state),
        .poison         (poison),
        .Mem_Req_Valid  (Mem_Req_Valid),
        .Mem_Req_Addr   (Mem_Req_Addr),
        .wr_en_c        (wr_en_c),
        .wr_last_c      (wr_last_c),
        .wr_index_c     (wr_index_c),
        .wr_beat_c      (wr_beat_c),
        .wr_tag_c       (wr_tag_c)
    );

    // Flush wins over a completing fill so a flushed line never comes back valid.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q <= '0;
        end else if (Flush) begin
            valid_q <= '0;
        end else if (wr_last_c && !poison) begin
            valid_q[wr_index_c] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en_c) data_q[{wr_index_c, wr_beat_c}] <= Mem_Resp_Data;
        if (wr_last_c) tag_q[wr_index_c] <= wr_tag_c;
    end

`ifdef ICACHE_STATS_EN
    // Saturating event counters; a miss is counted on the IDLE to REQ step.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Hit_Count  <= '0;
            Miss_Count <= '0;
        end else begin
            if (hit && (Hit_Count != 32'hFFFF_FFFF)) Hit_Count <= Hit_Count + 32'd1;
            if ((state == IDLE) && !lookup_match) begin
                if (Miss_Count != 32'hFFFF_FFFF) Miss_Count <= Miss_Count + 32'd1;
                $display("icache miss addr=%h index=%0d", Instr_address_2IM, addr_idx);
            end
        end
    end
`endif

endmodule
